// File: rtl/student_tlul_host.sv
`default_nettype none
// ============================================================================
//  Module      : student_tlul_host (with tlul_pkg)
//  Description : Single-outstanding TL-UL host. Turns a simple command /
//                response handshake into TL-UL Get / PutFullData transfers,
//                with response timeout, response checking and a counter of
//                successfully completed transactions.
//  Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//                cmd_*_i / cmd_ready_o   - command request handshake
//                rsp_*_o                 - one-cycle response strobe + flags/data
//                txn_cnt_o               - count of error-free responses
//                tl_o / tl_i             - TL-UL request / response channels
//  Revision    : 1.0 - initial release
// ============================================================================

package tlul_pkg;

    localparam logic [2:0] c_OP_PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] c_OP_PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] c_OP_GET              = 3'h4;
    localparam logic [2:0] c_OP_ACCESS_ACK       = 3'h0;
    localparam logic [2:0] c_OP_ACCESS_ACK_DATA  = 3'h1;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
    } tl_a_user_t;

    // instr_type encodes "not an instruction fetch" as a multi-bit false value.
    localparam tl_a_user_t c_TL_A_USER_DEFAULT = '{rsvd: 5'h00, instr_type: 4'h9};

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module student_tlul_host #(
    parameter logic [7:0]  SourceId      = 8'h00,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntW          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [31:0]          cmd_wdata_i,
    input  logic [3:0]           cmd_be_i,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 rsp_timeout_o,
    output logic [CntW-1:0]      txn_cnt_o,
    output tlul_pkg::tl_h2d_t    tl_o,
    input  tlul_pkg::tl_d2h_t    tl_i
);

    // Counter must be able to hold TimeoutCycles-1, the value at which the
    // last waiting cycle expires.
    localparam int unsigned      c_TO_W    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [c_TO_W-1:0] to_cnt_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_error_q;
    logic              rsp_timeout_q;
    logic [CntW-1:0]   txn_cnt_q;

    logic w_timeout;
    logic w_op_mismatch;
    logic w_src_mismatch;
    logic w_rsp_error;

    // Response fields not used by this host.
    logic w_unused_tl;
    assign w_unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

    assign w_timeout      = (to_cnt_q == c_TO_LAST);
    assign w_op_mismatch  = we_q ? (tl_i.d_opcode != tlul_pkg::c_OP_ACCESS_ACK)
                                 : (tl_i.d_opcode != tlul_pkg::c_OP_ACCESS_ACK_DATA);
    assign w_src_mismatch = (tl_i.d_source != SourceId);
    assign w_rsp_error    = tl_i.d_error | w_op_mismatch | w_src_mismatch;

    // ------------------------------------------------------------------
    // FSM next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (tl_i.a_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the expiry cycle is still accepted.
                if (tl_i.d_valid || w_timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // TL-UL request channel; a_* fields come straight from the command
    // registers so they stay stable for the whole REQ phase.
    // ------------------------------------------------------------------
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = (state_q == REQ);
        tl_o.a_opcode  = we_q ? tlul_pkg::c_OP_PUT_FULL_DATA : tlul_pkg::c_OP_GET;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = SourceId;
        tl_o.a_address = addr_q;
        tl_o.a_mask    = be_q;
        tl_o.a_data    = we_q ? wdata_q : 32'h0;
        tl_o.a_user    = tlul_pkg::c_TL_A_USER_DEFAULT;
        // Always ready: stray responses outside WAIT_RSP are drained and ignored.
        tl_o.d_ready   = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            be_q          <= 4'h0;
            to_cnt_q      <= '0;
            rsp_rdata_q   <= 32'h0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            txn_cnt_q     <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && cmd_valid_i) begin
                we_q    <= cmd_we_i;
                addr_q  <= {cmd_addr_i[31:2], 2'b00};
                wdata_q <= cmd_wdata_i;
                be_q    <= cmd_be_i;
            end

            if (state_q == REQ) begin
                to_cnt_q <= '0;
            end else if (state_q == WAIT_RSP) begin
                to_cnt_q <= to_cnt_q + c_TO_W'(1);
            end

            if (state_q == WAIT_RSP) begin
                if (tl_i.d_valid) begin
                    rsp_rdata_q   <= we_q ? 32'h0 : tl_i.d_data;
                    rsp_error_q   <= w_rsp_error;
                    rsp_timeout_q <= 1'b0;
                end else if (w_timeout) begin
                    rsp_rdata_q   <= 32'h0;
                    rsp_error_q   <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                end
            end

            if (state_q == RESP && !rsp_error_q) begin
                txn_cnt_q <= txn_cnt_q + CntW'(1);
            end
        end
    end

    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign txn_cnt_o     = txn_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_student_tlul_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_student_tlul_host
//  Description : Directed self-checking bench for student_tlul_host with a
//                hand-driven TL-UL device (TimeoutCycles = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_student_tlul_host;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_be;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              rsp_timeout;
    logic [15:0]       txn_cnt;
    tlul_pkg::tl_h2d_t tl_h;
    tlul_pkg::tl_d2h_t tl_d;

    int n_total  = 0;
    int n_passed = 0;
    int n_failed = 0;

    student_tlul_host #(
        .SourceId      (8'h00),
        .TimeoutCycles (16),
        .CntW          (16)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .cmd_be_i      (cmd_be),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_error_o   (rsp_error),
        .rsp_timeout_o (rsp_timeout),
        .txn_cnt_o     (txn_cnt),
        .tl_o          (tl_h),
        .tl_i          (tl_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns in the REQ cycle.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        step();
        cmd_valid = 1'b0;
    endtask

    // Device drives one response beat; returns one cycle later.
    task automatic respond(input logic [2:0] op, input logic [7:0] src,
                           input logic [31:0] data, input logic err);
        tl_d.d_valid  = 1'b1;
        tl_d.d_opcode = op;
        tl_d.d_source = src;
        tl_d.d_data   = data;
        tl_d.d_error  = err;
        step();
        tl_d.d_valid  = 1'b0;
        tl_d.d_error  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_be    = 4'h0;
        tl_d         = '0;
        tl_d.a_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_a_valid", tl_h.a_valid, 0);
        chk("rst_d_ready", tl_h.d_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_error", rsp_error, 0);
        chk("rst_timeout", rsp_timeout, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        rst = 1'b0;
        step();

        // Write, zero-wait device
        chk("wr_cmd_ready", cmd_ready, 1);
        issue(1'b1, 32'h4, 32'h2, 4'hF);
        chk("wr_a_valid", tl_h.a_valid, 1);
        chk("wr_a_opcode", tl_h.a_opcode, 0);
        chk("wr_a_address", tl_h.a_address, 32'h4);
        chk("wr_a_mask", tl_h.a_mask, 4'hF);
        chk("wr_a_data", tl_h.a_data, 32'h2);
        chk("wr_a_size", tl_h.a_size, 2);
        chk("wr_a_source", tl_h.a_source, 0);
        chk("wr_cmd_ready_busy", cmd_ready, 0);
        step();
        chk("wr_wait_a_valid", tl_h.a_valid, 0);
        chk("wr_wait_rsp_valid", rsp_valid, 0);
        respond(3'h0, 8'h00, 32'h0, 1'b0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_error", rsp_error, 0);
        chk("wr_rsp_timeout", rsp_timeout, 0);
        chk("wr_resp_cmd_ready", cmd_ready, 0);
        step();
        chk("wr_rsp_valid_off", rsp_valid, 0);
        chk("wr_txn_cnt", txn_cnt, 1);
        chk("wr_cmd_ready_back", cmd_ready, 1);

        // Read, misaligned address
        issue(1'b0, 32'h1, 32'hDEADBEEF, 4'hF);
        chk("rd_a_opcode", tl_h.a_opcode, 4);
        chk("rd_a_address", tl_h.a_address, 32'h0);
        chk("rd_a_data", tl_h.a_data, 32'h0);
        step();
        respond(3'h1, 8'h00, 32'h0000AFFE, 1'b0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 32'h0000AFFE);
        chk("rd_error", rsp_error, 0);
        step();
        chk("rd_txn_cnt", txn_cnt, 2);
        chk("rd_rdata_hold", rsp_rdata, 32'h0000AFFE);

        // a_ready stall: five cycles low, accepted in the sixth
        tl_d.a_ready = 1'b0;
        issue(1'b1, 32'h10, 32'h12345678, 4'h3);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) tl_d.a_ready = 1'b1;
            chk("st_a_valid", tl_h.a_valid, 1);
            chk("st_a_opcode", tl_h.a_opcode, 0);
            chk("st_a_address", tl_h.a_address, 32'h10);
            chk("st_a_data", tl_h.a_data, 32'h12345678);
            chk("st_a_mask", tl_h.a_mask, 4'h3);
            step();
        end
        chk("st_wait_a_valid", tl_h.a_valid, 0);
        respond(3'h0, 8'h00, 32'h0, 1'b0);
        chk("st_rsp_valid", rsp_valid, 1);
        chk("st_error", rsp_error, 0);
        chk("st_timeout", rsp_timeout, 0);
        step();
        chk("st_txn_cnt", txn_cnt, 3);

        // Timeout: response strobe 17 cycles after the handshake cycle
        issue(1'b0, 32'h20, 32'h0, 4'hF);
        step();
        for (int k = 1; k <= 15; k++) begin
            chk("to_wait_rsp_valid", rsp_valid, 0);
            step();
        end
        chk("to_last_rsp_valid", rsp_valid, 0);
        step();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_timeout", rsp_timeout, 1);
        chk("to_error", rsp_error, 1);
        chk("to_rdata", rsp_rdata, 0);
        step();
        chk("to_txn_cnt", txn_cnt, 3);
        respond(3'h1, 8'h00, 32'h00005555, 1'b0);
        chk("late_rsp_valid", rsp_valid, 0);
        chk("late_rdata", rsp_rdata, 0);
        chk("late_txn_cnt", txn_cnt, 3);
        chk("late_cmd_ready", cmd_ready, 1);

        // d_error on a read
        issue(1'b0, 32'h8, 32'h0, 4'hF);
        step();
        respond(3'h1, 8'h00, 32'h0000BEEF, 1'b1);
        chk("derr_rsp_valid", rsp_valid, 1);
        chk("derr_error", rsp_error, 1);
        chk("derr_timeout", rsp_timeout, 0);
        chk("derr_rdata", rsp_rdata, 32'h0000BEEF);
        step();
        chk("derr_txn_cnt", txn_cnt, 3);

        // AccessAckData answering a write
        issue(1'b1, 32'h8, 32'h1, 4'hF);
        step();
        respond(3'h1, 8'h00, 32'h0, 1'b0);
        chk("oper_error", rsp_error, 1);
        step();
        chk("oper_txn_cnt", txn_cnt, 3);

        // Wrong source id
        issue(1'b0, 32'h8, 32'h0, 4'hF);
        step();
        respond(3'h1, 8'h01, 32'h00001234, 1'b0);
        chk("srcerr_error", rsp_error, 1);
        step();
        chk("srcerr_txn_cnt", txn_cnt, 3);

        // Response on the expiry cycle wins over the timeout
        issue(1'b0, 32'hC, 32'h0, 4'hF);
        step();
        for (int k = 1; k <= 15; k++) step();
        respond(3'h1, 8'h00, 32'h0000CAFE, 1'b0);
        chk("race_rsp_valid", rsp_valid, 1);
        chk("race_timeout", rsp_timeout, 0);
        chk("race_error", rsp_error, 0);
        chk("race_rdata", rsp_rdata, 32'h0000CAFE);
        step();
        chk("race_txn_cnt", txn_cnt, 4);

        // Reset while waiting for a response
        issue(1'b1, 32'h4, 32'h3, 4'hF);
        step();
        step();
        chk("mr_busy_cmd_ready", cmd_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_cmd_ready", cmd_ready, 1);
        chk("mr_a_valid", tl_h.a_valid, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_txn_cnt", txn_cnt, 0);
        for (int k = 0; k < 20; k++) step();
        chk("mr_no_late_rsp", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
